fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_regfile.sv | 27 ++
 rtl/fetch_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch/store unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [3:0] REG_REGION = 4'hC;

   localparam logic ERR_NONE    = 1'b0;
   localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/fetch_regfile.sv
// fetch_regfile: per-thread register window storage.
// One synchronous write port, one registered read port (1-cycle latency).
module fetch_regfile #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int IW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [IW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [IW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: serves requests from a per-thread register window or the W-bus.
// Define FETCH_TIMEOUT_EN to abort stalled bus transfers with err.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DATA_W          = 32,
   parameter int ADDR_W          = 32,
   parameter int THREADS         = 4,
   parameter int REGS_PER_THREAD = 8,
   parameter int TIMEOUT         = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       f_enable,
   input  logic                       write_mode,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          data_i,
   input  logic [$clog2(THREADS)-1:0] thread,
   output logic [DATA_W-1:0]          data_o,
   output logic                       ack,
   output logic                       err,
   input  logic                       W_ACK,
   input  logic [DATA_W-1:0]          W_DATA_I,
   output logic [DATA_W-1:0]          W_DATA_O,
   output logic [ADDR_W-1:0]          W_ADDR,
   output logic                       W_WRITE,
   output logic                       W_STB
);

   localparam int TW = $clog2(THREADS);
   localparam int RW = $clog2(REGS_PER_THREAD);
   localparam int IW = TW + RW;

   if (ADDR_W < 8 || THREADS < 2 || (THREADS & (THREADS - 1)) != 0 ||
       REGS_PER_THREAD < 2 ||
       (REGS_PER_THREAD & (REGS_PER_THREAD - 1)) != 0 ||
       TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
      $error("fetch_unit: illegal parameter value");
   end

   state_e            state_q, state_d;
   logic              ack_q, ack_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [DATA_W-1:0] w_wdata_q, w_wdata_d;
   logic              w_write_q, w_write_d;
   logic              w_stb_q, w_stb_d;
   logic [DATA_W-1:0] bus_data_q, bus_data_d;
   logic              src_rf_q, src_rf_d;
   logic              err_q, err_d;

   logic              req;
   logic              is_reg;
   logic [IW-1:0]     rf_idx;
   logic              rf_we;
   logic              rf_re;
   logic [DATA_W-1:0] rf_rdata;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] cnt_q, cnt_d;
`endif

   assign req    = (state_q == S_IDLE) && f_enable;
   assign is_reg = (addr[ADDR_W-1 -: 4] == REG_REGION);
   assign rf_idx = {thread, addr[RW-1:0]};
   assign rf_we  = req && is_reg && write_mode;
   assign rf_re  = req && is_reg && !write_mode;

   fetch_regfile #(
      .DATA_W (DATA_W),
      .DEPTH  (THREADS * REGS_PER_THREAD),
      .IW     (IW)
   ) u_regfile (
      .clk     (clk),
      .we_i    (rf_we),
      .waddr_i (rf_idx),
      .wdata_i (data_i),
      .re_i    (rf_re),
      .raddr_i (rf_idx),
      .rdata_o (rf_rdata)
   );

   always_comb begin
      state_d    = state_q;
      ack_d      = ack_q;
      err_d      = err_q;
      w_addr_d   = w_addr_q;
      w_wdata_d  = w_wdata_q;
      w_write_d  = w_write_q;
      w_stb_d    = w_stb_q;
      bus_data_d = bus_data_q;
      src_rf_d   = src_rf_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (f_enable) begin
               unique case (1'b1)
                  is_reg: begin
                     if (!write_mode) src_rf_d = 1'b1;
                     ack_d   = 1'b1;
                     state_d = S_DONE;
                  end
                  !is_reg: begin
                     w_addr_d  = addr;
                     w_wdata_d = data_i;
                     w_write_d = write_mode;
                     w_stb_d   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                     cnt_d     = '0;
`endif
                     state_d   = S_WAIT;
                  end
                  default: ;
               endcase
            end
         end
         S_WAIT: begin
            // acknowledge takes priority over a same-cycle expiry
            if (W_ACK) begin
               if (!w_write_q) begin
                  bus_data_d = W_DATA_I;
                  src_rf_d   = 1'b0;
               end
               w_stb_d   = 1'b0;
               w_write_d = 1'b0;
               ack_d     = 1'b1;
               state_d   = S_DONE;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               if (!w_write_q) begin
                  bus_data_d = '1;
                  src_rf_d   = 1'b0;
               end
               w_stb_d   = 1'b0;
               w_write_d = 1'b0;
               ack_d     = 1'b1;
               err_d     = ERR_TIMEOUT;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         S_DONE: begin
            ack_d   = 1'b0;
            err_d   = ERR_NONE;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ack_q      <= 1'b0;
         err_q      <= ERR_NONE;
         w_addr_q   <= '0;
         w_wdata_q  <= '0;
         w_write_q  <= 1'b0;
         w_stb_q    <= 1'b0;
         bus_data_q <= '0;
         src_rf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         w_addr_q   <= w_addr_d;
         w_wdata_q  <= w_wdata_d;
         w_write_q  <= w_write_d;
         w_stb_q    <= w_stb_d;
         bus_data_q <= bus_data_d;
         src_rf_q   <= src_rf_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
   assign err = err_q;
`else
   assign err = ERR_NONE;
`endif

   // register loads are read straight from the window's registered port
   assign data_o   = src_rf_q ? rf_rdata : bus_data_q;
   assign ack      = ack_q;
   assign W_ADDR   = w_addr_q;
   assign W_DATA_O = w_wdata_q;
   assign W_WRITE  = w_write_q;
   assign W_STB    = w_stb_q;

endmodule
